// File: rtl/alu_exec_pkg.sv
// Shared ALU definitions: operation codes, shift kinds and the result record.
// Every ALU block imports this package instead of redefining the OP_* codes.
package alu_exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_BGE  = 4'd10;
  localparam logic [3:0] OP_BGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd15;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_t;

  typedef struct packed {
    logic [31:0] value;
    logic        err;
  } alu_res_t;

  function automatic logic is_shift(input logic [3:0] func);
    return (func == OP_SLL) || (func == OP_SRL) || (func == OP_SRA);
  endfunction

  function automatic shift_kind_t shift_kind(input logic [3:0] func);
    case (func)
      OP_SRL:  shift_kind = SH_SRL;
      OP_SRA:  shift_kind = SH_SRA;
      default: shift_kind = SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request/result handshake bundle between the issue stage and the ALU.
interface alu_exec_if;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_err;

  modport master (
    output in_valid, alu_func, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_err
  );

  modport slave (
    input  in_valid, alu_func, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_err
  );

endinterface

// File: rtl/alu_shift_step.sv
// Single-bit shift of a 32-bit word; the iterative shifter applies it once per cycle.
module alu_shift_step
  import alu_exec_pkg::*;
(
  input  shift_kind_t kind,
  input  logic [31:0] word,
  output logic [31:0] shifted
);

  // one-position shift selected by kind; SRA keeps the sign bit
  always_comb begin
    shifted = word;
    case (kind)
      SH_SLL:  shifted = {word[30:0], 1'b0};
      SH_SRL:  shifted = {1'b0, word[31:1]};
      SH_SRA:  shifted = {word[31], word[31:1]};
      default: shifted = {word[30:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Handshaked ALU execute unit: single-cycle logic/arithmetic ops, iterative shifts,
// result held in DONE until the consumer takes it.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  alu_exec_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [31:0] result;
  logic        zero;
  logic        err;
  logic [31:0] work;
  logic [4:0]  cnt;
  shift_kind_t kind;
  logic [31:0] step_out;
  logic        accept;
  alu_res_t    op_res;

  function automatic alu_res_t alu_eval(input logic [3:0] func,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    alu_res_t r;
    r.err = 1'b0;
    case (func)
      OP_ADD:  r.value = a + b;
      OP_SUB:  r.value = a - b;
      OP_XOR:  r.value = a ^ b;
      OP_OR:   r.value = a | b;
      OP_AND:  r.value = a & b;
      OP_SLT:  r.value = {31'b0, ($signed(a) < $signed(b))};
      OP_SLTU: r.value = {31'b0, (a < b)};
      OP_BGE:  r.value = {31'b0, ($signed(a) >= $signed(b))};
      OP_BGEU: r.value = {31'b0, (a >= b)};
      // a zero-distance shift completes immediately with the operand unchanged
      OP_SLL, OP_SRL, OP_SRA: r.value = a;
      default: begin
        r.value = 32'h0;
        r.err   = 1'b1;
      end
    endcase
    return r;
  endfunction

  // a finished result can be handed over and a new request taken in the same cycle
  assign bus.in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = (state == ST_DONE);
  assign bus.out_result = result;
  assign bus.out_zero   = zero;
  assign bus.out_err    = err;

  alu_shift_step u_shift_step (
    .kind    (kind),
    .word    (work),
    .shifted (step_out)
  );

  // evaluate the single-cycle result from the live request operands
  always_comb begin
    op_res = alu_eval(bus.alu_func, bus.in_a, bus.in_b);
  end

  // control FSM, result register and iterative shifter state
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= 32'h0;
      zero   <= 1'b1;
      err    <= 1'b0;
      work   <= 32'h0;
      cnt    <= 5'd0;
      kind   <= SH_SLL;
    end else begin
      case (state)
        ST_SHIFT: begin
          work <= step_out;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state  <= ST_DONE;
            result <= step_out;
            zero   <= (step_out == 32'h0);
            err    <= 1'b0;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_shift(bus.alu_func) && (bus.in_b[4:0] != 5'd0)) begin
              state <= ST_SHIFT;
              work  <= bus.in_a;
              cnt   <= bus.in_b[4:0];
              kind  <= shift_kind(bus.alu_func);
            end else begin
              state  <= ST_DONE;
              result <= op_res.value;
              zero   <= (op_res.value == 32'h0);
              err    <= op_res.err;
            end
          end else if ((state == ST_DONE) && bus.out_ready) begin
            state <= ST_IDLE;
          end else begin
            state <= state;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: vector table through a scoreboard, plus
// stall/back-to-back and mid-shift reset sequences.
module tb_alu_exec;
  import alu_exec_pkg::*;

  typedef struct {
    logic [3:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic seen = 1'b0;
  logic in_shift = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_if bus();

  alu_exec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int exp_latency(input logic [3:0] f, input logic [31:0] b);
    if ((f == OP_SLL || f == OP_SRL || f == OP_SRA) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // result monitor: latency, held values while stalled, scoreboard pop on handover
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (in_shift && bus.out_valid !== 1'b1)
        chk("shift_in_ready", {31'b0, bus.in_ready}, 32'h0);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h, expected no result", bus.out_result);
        end else begin
          e = exp_q[0];
          if (!seen) begin
            chk("latency", cyc, e.due);
            seen     = 1'b1;
            in_shift = 1'b0;
          end
          chk("result", bus.out_result, e.res);
          chk("zero", {31'b0, bus.out_zero}, {31'b0, (e.res == 32'h0)});
          chk("err", {31'b0, bus.out_err}, {31'b0, e.err});
          if (bus.out_ready === 1'b1) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  endtask

  // present one request, wait (bounded) for acceptance, then scramble the inputs
  task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic err, input bit track);
    int   w;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.alu_func = f;
    bus.in_a     = a;
    bus.in_b     = b;
    w = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, expected 1", bus.in_ready);
    end
    if (track) begin
      e.res = res;
      e.err = err;
      e.due = cyc + exp_latency(f, b);
      exp_q.push_back(e);
    end
    tick();
    if (track && exp_latency(f, b) > 1) in_shift = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_func = 4'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    tick();
  endtask

  initial begin
    vecs.push_back('{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back('{OP_ADD,  32'h00000003, 32'h00000004, 32'h00000007, 1'b0});
    vecs.push_back('{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{OP_XOR,  32'h000000F0, 32'h000000FF, 32'h0000000F, 1'b0});
    vecs.push_back('{OP_OR,   32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0});
    vecs.push_back('{OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0});
    vecs.push_back('{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
    vecs.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back('{OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{OP_BGE,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back('{OP_BGE,  32'h00000005, 32'h00000005, 32'h00000001, 1'b0});
    vecs.push_back('{OP_BGEU, 32'h00000005, 32'h00000005, 32'h00000001, 1'b0});
    vecs.push_back('{OP_BGEU, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{OP_SLL,  32'h00000001, 32'h0000000A, 32'h00000400, 1'b0});
    vecs.push_back('{OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0});
    vecs.push_back('{OP_SRA,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{OP_SRA,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0});
    vecs.push_back('{OP_SLL,  32'h00001234, 32'h00000020, 32'h00001234, 1'b0});
    vecs.push_back('{OP_SRL,  32'h000000F0, 32'hFFFFFFE1, 32'h00000078, 1'b0});
    vecs.push_back('{OP_SLL,  32'h80000001, 32'h00000001, 32'h00000002, 1'b0});
    vecs.push_back('{OP_EEE,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1});
    vecs.push_back('{OP_ADD,  32'h00000001, 32'h00000001, 32'h00000002, 1'b0});
    vecs.push_back('{4'd13,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    vecs.push_back('{OP_SUB,  32'h00000009, 32'h00000002, 32'h00000007, 1'b0});

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_func  = OP_ADD;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b1;
    fork
      monitor_loop();
    join_none
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_out_zero", {31'b0, bus.out_zero}, 32'h1);
    chk("rst_out_err", {31'b0, bus.out_err}, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err, 1'b1);
      drain();
    end

    // stalled consumer: ADD held for 5 cycles, then SUB accepted on the handover cycle
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
    end
    tick();
    bus.out_ready = 1'b1;
    send(OP_SUB, 32'd7, 32'd7, 32'd0, 1'b0, 1'b1);
    drain();

    // reset in the middle of a 10-step shift discards it
    send(OP_SLL, 32'd1, 32'd10, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("midrst_out_result", bus.out_result, 32'h0);
    chk("midrst_out_zero", {31'b0, bus.out_zero}, 32'h1);
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {31'b0, bus.out_valid}, 32'h0);
    end
    tick();
    send(OP_XOR, 32'h000000F0, 32'h000000FF, 32'h0000000F, 1'b0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
